spirxdata: RTL and testbench
============================

Name: spirxdata

Overview:
- Receive-side data path for the shared-SPI SD-card controller; counterpart to the block-write transmitter.
- After a read command, clocks 0xFF bytes through the low-level SPI byte engine and waits for the 0xFE start token.
- Packs the 2^lgblksz data bytes MSB-first into DW-bit words, writes them to the controller's FIFO memory, and checks the trailing CRC16.
- Reports done/error status to the command controller.

Parameters:
DW, 32, memory word width in bits; multiple of 8.
AW, 8, memory address width; MSB selects FIFO.
TOKEN_TIMEOUT, 4095, maximum bytes examined while waiting for the start token.

Ports:
i_clk  input  1  system clock (single clock domain)
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  begin block receive; sampled only when !o_busy
i_lgblksz  input  4  log2 block size in bytes; clipped to 4..9
i_fifo  input  1  target FIFO select; becomes o_addr[AW-1]
o_busy  output  1  transfer in progress
o_write  output  1  one-cycle memory write strobe
o_addr  output  AW  memory write address
o_data  output  DW  memory write data
i_ll_busy  input  1  low-level SPI engine busy; request accepted when o_ll_stb && !i_ll_busy
o_ll_stb  output  1  byte request to low-level engine
o_ll_byte  output  8  byte to transmit; constant 8'hff
i_ll_stb  input  1  received byte valid
i_ll_byte  input  8  received byte
o_done  output  1  one-cycle pulse at end of transfer (success or error)
o_errcode  output  2  status, valid with o_done: 0 ok, 1 data-error token, 2 token timeout, 3 CRC mismatch

Behaviour:
- Reset state: o_busy, o_write, o_ll_stb, o_done = 0; o_errcode = 0; o_addr = 0; o_data = 0; state IDLE. Reset mid-transfer aborts immediately, with no o_done and no further writes.
- At most one byte outstanding:
  - o_ll_stb rises when no request is pending.
  - o_ll_stb falls on the cycle after acceptance.
  - o_ll_stb stays low until the matching i_ll_stb.
  - i_ll_stb with nothing outstanding is ignored.
- IDLE:
  - On i_start, latch clipped lgblksz.
  - o_addr <= {i_fifo, 0}; clear byte counter, timeout counter and CRC.
  - o_busy <= 1; go to TOKEN.
  - i_start while busy is ignored.
- TOKEN, per received byte:
  - 0xFE -> DATA.
  - Upper nibble 0000 and byte != 0 (data-error token) -> FINISH, errcode 1.
  - Any other byte increments the timeout counter; when the count reaches TOKEN_TIMEOUT -> FINISH, errcode 2.
- DATA:
  - Each received byte shifts into o_data from the LSB end, so the first byte lands in o_data[DW-1:DW-8].
  - Each byte updates CRC16-CCITT (poly 0x1021, init 0x0000, MSB-first, 8 bits per cycle).
  - After every DW/8 bytes: o_write pulses for 1 cycle the cycle after the last byte's i_ll_stb, with current o_addr/o_data.
  - o_addr[AW-2:0] increments the cycle after o_write; o_addr[AW-1] is held.
  - After byte 2^lgblksz -> CRC.
- CRC:
  - Two more bytes are requested and fed through the same CRC update.
  - After the second byte -> FINISH; errcode 0 if the CRC register is 0x0000, else 3.
  - Data writes already issued are not retracted.
- FINISH: no outstanding request; o_done = 1 for one cycle with o_errcode; o_busy <= 0 on the same edge; return to IDLE.
- Word count per block: 2^lgblksz/(DW/8); lgblksz=4 gives 4 writes, lgblksz=9 gives 128 writes, addresses 0..127.
- Byte counter width: 10 bits (max 514). Timeout counter width: clog2(TOKEN_TIMEOUT+1).
- o_ll_byte is always 8'hff, including during token wait and CRC.
- o_ll_stb is never asserted in IDLE or FINISH.

Decomposition:
- Shared package sdspi_pkg:
  - CRC_POLYNOMIAL = 16'h1021.
  - START_TOKEN = 8'hfe; IDLE_BYTE = 8'hff.
  - errcode constants ERR_NONE/ERR_TOKEN/ERR_TIMEOUT/ERR_CRC.
  - rx state enum (IDLE, TOKEN, DATA, CRC, FINISH).
- Sub-module spicrc8: combinational 8-bit-per-step CRC16 update (crc_in, byte_in -> crc_out).

Test Plan:
- Three 0xFF bytes, then 0xFE, then 16 bytes 00..0F plus correct CRC, lgblksz=4, i_fifo=0 -> writes at addr 0..3 with data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; o_done with errcode 0; exactly 22 accepted requests.
- Same payload with i_fifo=1, lgblksz=9, 512 bytes -> 128 writes, addr 0x80..0xFF; errcode 0; addr MSB never toggles.
- Token wait returns 0x05 -> no writes; o_done with errcode 1 after 1 byte.
- TOKEN_TIMEOUT=8, all 0xFF -> o_done with errcode 2 after exactly 8 bytes; o_ll_stb low afterwards.
- Correct data, last CRC byte XOR 0x01 -> all 4 writes occur; errcode 3.
- Random i_ll_busy stalls plus spurious i_ll_stb while idle, then i_reset asserted mid-DATA -> outputs clear asynchronously; no o_done; a fresh i_start completes normally.

Source files
------------

// File: rtl/sdspi_pkg.sv
// Shared definitions for the SD-card SPI controller data paths: protocol bytes,
// CRC polynomial, status codes and the receive FSM state type.
package sdspi_pkg;

    localparam logic [15:0] CRC_POLYNOMIAL = 16'h1021;
    localparam logic [7:0]  START_TOKEN    = 8'hfe;
    localparam logic [7:0]  IDLE_BYTE      = 8'hff;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TOKEN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CRC     = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StData,
        StCrc,
        StFinish
    } rx_state_e;

    // Block sizes below 16 or above 512 bytes are not supported by the card.
    function automatic logic [3:0] clip_lgblksz(input logic [3:0] lg);
        if (lg < 4'd4) begin
            return 4'd4;
        end else if (lg > 4'd9) begin
            return 4'd9;
        end
        return lg;
    endfunction

endpackage

// File: rtl/spirxdata_if.sv
// Command, memory-write and low-level SPI byte-engine signals of the block receiver.
// The master side is the command controller plus byte engine; the slave side is spirxdata.
interface spirxdata_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
);
    logic          i_start;
    logic [3:0]    i_lgblksz;
    logic          i_fifo;
    logic          o_busy;
    logic          o_write;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          i_ll_busy;
    logic          o_ll_stb;
    logic [7:0]    o_ll_byte;
    logic          i_ll_stb;
    logic [7:0]    i_ll_byte;
    logic          o_done;
    logic [1:0]    o_errcode;

    modport master (
        output i_start, i_lgblksz, i_fifo, i_ll_busy, i_ll_stb, i_ll_byte,
        input  o_busy, o_write, o_addr, o_data, o_ll_stb, o_ll_byte, o_done, o_errcode
    );

    modport slave (
        input  i_start, i_lgblksz, i_fifo, i_ll_busy, i_ll_stb, i_ll_byte,
        output o_busy, o_write, o_addr, o_data, o_ll_stb, o_ll_byte, o_done, o_errcode
    );

endinterface

// File: rtl/spicrc8.sv
// Combinational CRC16-CCITT update, one byte per step, MSB first.
module spicrc8
    import sdspi_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ byte_in[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLYNOMIAL;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/spirxdata.sv
// SD-card block read data path: waits for the start token, packs data bytes MSB-first into
// memory words, checks the trailing CRC16 and reports status to the command controller.
module spirxdata
    import sdspi_pkg::*;
#(
    parameter int unsigned DW            = 32,
    parameter int unsigned AW            = 8,
    parameter int unsigned TOKEN_TIMEOUT = 4095
) (
    input  logic        i_clk,
    input  logic        i_reset,
    spirxdata_if.slave  bus
);

    localparam int unsigned BPW = DW / 8;
    localparam int unsigned WbW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned TW  = $clog2(TOKEN_TIMEOUT + 1);

    rx_state_e     state_q, state_d;
    logic [3:0]    lgblksz_q, lgblksz_d;
    logic [9:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [WbW-1:0] wb_q, wb_d;
    logic [15:0]   crc_q, crc_d, crc_next;
    logic          pend_q, pend_d;
    logic          ll_stb_q, ll_stb_d;
    logic          busy_q, busy_d;
    logic          write_q, write_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    logic       accept, rx;
    logic [9:0] blk_bytes;
    logic       last_data, last_crc, err_token, tmo_hit, wb_last;

    assign accept    = ll_stb_q && !bus.i_ll_busy;
    // Only a byte matching an outstanding request is consumed.
    assign rx        = pend_q && bus.i_ll_stb;
    assign blk_bytes = 10'd1 << lgblksz_q;
    assign last_data = (bcnt_q == blk_bytes - 10'd1);
    assign last_crc  = (bcnt_q == blk_bytes + 10'd1);
    assign err_token = (bus.i_ll_byte[7:4] == 4'h0) && (bus.i_ll_byte != 8'h00);
    assign tmo_hit   = (tmo_q == TW'(TOKEN_TIMEOUT - 1));
    assign wb_last   = (wb_q == WbW'(BPW - 1));

    spicrc8 u_crc (
        .crc_in  (crc_q),
        .byte_in (bus.i_ll_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) state_d = StToken;
            end
            StToken: begin
                if (rx) begin
                    if (bus.i_ll_byte == START_TOKEN) begin
                        state_d = StData;
                    end else if (err_token || tmo_hit) begin
                        state_d = StFinish;
                    end
                end
            end
            StData: begin
                if (rx && last_data) state_d = StCrc;
            end
            StCrc: begin
                if (rx && last_crc) state_d = StFinish;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        lgblksz_d = lgblksz_q;
        bcnt_d    = bcnt_q;
        tmo_d     = tmo_q;
        wb_d      = wb_q;
        crc_d     = crc_q;
        busy_d    = busy_q;
        err_d     = err_q;
        addr_d    = addr_q;
        data_d    = data_q;
        write_d   = 1'b0;
        done_d    = 1'b0;

        if (accept) begin
            pend_d = 1'b1;
        end else if (rx) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        // The FIFO-select bit is fixed for the whole block.
        if (write_q) addr_d[AW-2:0] = addr_q[AW-2:0] + (AW-1)'(1);

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    lgblksz_d = clip_lgblksz(bus.i_lgblksz);
                    addr_d    = {bus.i_fifo, {(AW-1){1'b0}}};
                    bcnt_d    = '0;
                    tmo_d     = '0;
                    wb_d      = '0;
                    crc_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            StToken: begin
                if (rx && bus.i_ll_byte != START_TOKEN) begin
                    if (err_token) begin
                        err_d = ERR_TOKEN;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                        if (tmo_hit) err_d = ERR_TIMEOUT;
                    end
                end
            end
            StData: begin
                if (rx) begin
                    data_d  = (data_q << 8) | DW'(bus.i_ll_byte);
                    crc_d   = crc_next;
                    bcnt_d  = bcnt_q + 10'd1;
                    wb_d    = wb_last ? '0 : wb_q + WbW'(1);
                    write_d = wb_last;
                end
            end
            StCrc: begin
                if (rx) begin
                    crc_d  = crc_next;
                    bcnt_d = bcnt_q + 10'd1;
                    if (last_crc) err_d = (crc_next == 16'h0000) ? ERR_NONE : ERR_CRC;
                end
            end
            StFinish: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase

        ll_stb_d = (state_d inside {StToken, StData, StCrc}) && !pend_d && !accept;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lgblksz_q <= 4'd4;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            wb_q      <= '0;
            crc_q     <= '0;
            pend_q    <= 1'b0;
            ll_stb_q  <= 1'b0;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_NONE;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            lgblksz_q <= lgblksz_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            wb_q      <= wb_d;
            crc_q     <= crc_d;
            pend_q    <= pend_d;
            ll_stb_q  <= ll_stb_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
            done_q    <= done_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_write   = write_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_data    = data_q;
    assign bus.o_ll_stb  = ll_stb_q;
    assign bus.o_ll_byte = IDLE_BYTE;
    assign bus.o_done    = done_q;
    assign bus.o_errcode = err_q;

endmodule

// File: tb/tb_spirxdata.sv
// Randomized bench for spirxdata: a byte-engine responder feeds token/data/CRC streams and a
// transfer-level model predicts the memory writes, status code and number of byte requests.
module tb_spirxdata;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spirxdata_if #(.DW(DW), .AW(AW)) bus ();

    spirxdata #(.DW(DW), .AW(AW), .TOKEN_TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    byte unsigned resp_q[$];
    byte unsigned pre[$];
    byte unsigned pay[$];
    byte unsigned full[$];
    wr_t          wr_q[$];
    wr_t          exp_wr[$];
    int           acc_cnt = 0;
    int           done_cnt = 0;
    logic [1:0]   err_seen = 2'd0;
    bit           msb_bad = 1'b0;
    bit           exp_fifo = 1'b0;
    bit           stall_en = 1'b0;
    bit           spur_en = 1'b0;
    int           exp_used = 0;
    int           exp_err = 0;

    // Remainder of M(x)*x^16 mod (x^16 + 0x1021) by long division.
    function automatic logic [15:0] poly_rem(input byte unsigned m[$]);
        logic [16:0] r;
        r = '0;
        for (int i = 0; i < m.size() + 2; i++) begin
            for (int b = 7; b >= 0; b--) begin
                r = {r[15:0], (i < m.size()) ? m[i][b] : 1'b0};
                if (r[16]) r = r ^ 17'h11021;
            end
        end
        return r[15:0];
    endfunction

    // Byte engine: accepts requests, answers after a random delay, injects idle noise.
    initial begin
        bit pend_e;
        int dly_e;
        pend_e = 1'b0;
        dly_e  = 0;
        bus.i_ll_stb  = 1'b0;
        bus.i_ll_byte = 8'h00;
        bus.i_ll_busy = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_ll_stb = 1'b0;
            if (rst) begin
                pend_e = 1'b0;
            end else if (pend_e) begin
                if (dly_e == 0) begin
                    bus.i_ll_stb  = 1'b1;
                    bus.i_ll_byte = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hff;
                    pend_e = 1'b0;
                end else begin
                    dly_e--;
                end
            end else if (spur_en && !bus.o_busy && $urandom_range(3) == 0) begin
                bus.i_ll_stb  = 1'b1;
                bus.i_ll_byte = 8'($urandom);
            end
            bus.i_ll_busy = stall_en && ($urandom_range(2) == 0);
            if (!rst && bus.o_ll_stb && !bus.i_ll_busy) begin
                acc_cnt++;
                pend_e = 1'b1;
                dly_e  = stall_en ? int'($urandom_range(2)) : 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.o_write) begin
                    wr_t w;
                    w.a = bus.o_addr;
                    w.d = bus.o_data;
                    wr_q.push_back(w);
                end
                if (bus.o_done) begin
                    done_cnt++;
                    err_seen = bus.o_errcode;
                end
                if (bus.o_busy && bus.o_addr[AW-1] !== exp_fifo) msb_bad = 1'b1;
            end
        end
    end

    task automatic prep_xfer(input logic [3:0] lg, input bit fifo, input int ntok,
                             input byte unsigned tok_end, input bit seq, input bit bad_crc);
        int  eff, n, tmo;
        bit  data_ph;
        logic [15:0] c;
        wr_t w;
        pre.delete(); pay.delete(); full.delete(); exp_wr.delete(); resp_q.delete();
        for (int i = 0; i < ntok; i++) pre.push_back(8'hff);
        pre.push_back(tok_end);
        exp_used = 0; exp_err = 0; data_ph = 1'b0; tmo = 0;
        for (int i = 0; i < pre.size(); i++) begin
            exp_used++;
            if (pre[i] == 8'hfe) begin
                data_ph = 1'b1;
                break;
            end else if (pre[i] < 8'h10 && pre[i] != 8'h00) begin
                exp_err = 1;
                break;
            end else begin
                tmo++;
                if (tmo == TMO) begin
                    exp_err = 2;
                    break;
                end
            end
        end
        foreach (pre[i]) resp_q.push_back(pre[i]);
        if (data_ph) begin
            eff = (lg < 4) ? 4 : ((lg > 9) ? 9 : int'(lg));
            n   = 1 << eff;
            for (int i = 0; i < n; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
            c = poly_rem(pay);
            foreach (pay[i]) full.push_back(pay[i]);
            full.push_back(c[15:8]);
            full.push_back(c[7:0] ^ (bad_crc ? 8'h01 : 8'h00));
            foreach (full[i]) resp_q.push_back(full[i]);
            exp_err  = (poly_rem(full) == 16'h0000) ? 0 : 3;
            exp_used += n + 2;
            for (int k = 0; k < n / 4; k++) begin
                w.a = {fifo, (AW-1)'(k)};
                w.d = {pay[4*k], pay[4*k+1], pay[4*k+2], pay[4*k+3]};
                exp_wr.push_back(w);
            end
        end
        wr_q.delete();
        done_cnt = 0; acc_cnt = 0; msb_bad = 1'b0; exp_fifo = fifo;
        @(negedge clk);
        bus.i_start   = 1'b1;
        bus.i_lgblksz = lg;
        bus.i_fifo    = fifo;
        @(negedge clk);
        bus.i_start   = 1'b0;
    endtask

    task automatic check_xfer(input string nm);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, ".done_seen"}, 64'(done_cnt > 0), 64'd1);
        repeat (4) @(negedge clk);
        check({nm, ".done_cnt"}, 64'(done_cnt), 64'd1);
        check({nm, ".errcode"}, 64'(err_seen), 64'(exp_err));
        check({nm, ".nwrites"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++) begin
            check($sformatf("%s.addr%0d", nm, k), 64'(wr_q[k].a), 64'(exp_wr[k].a));
            check($sformatf("%s.data%0d", nm, k), 64'(wr_q[k].d), 64'(exp_wr[k].d));
        end
        check({nm, ".requests"}, 64'(acc_cnt), 64'(exp_used));
        check({nm, ".ll_stb_after"}, 64'(bus.o_ll_stb), 64'd0);
        check({nm, ".busy_after"}, 64'(bus.o_busy), 64'd0);
        check({nm, ".addr_msb_held"}, 64'(msb_bad), 64'd0);
        resp_q.delete();
    endtask

    initial begin
        int cyc;
        bus.i_start   = 1'b0;
        bus.i_lgblksz = 4'd4;
        bus.i_fifo    = 1'b0;

        repeat (2) @(negedge clk);
        check("rst.busy",    64'(bus.o_busy),    64'd0);
        check("rst.write",   64'(bus.o_write),   64'd0);
        check("rst.ll_stb",  64'(bus.o_ll_stb),  64'd0);
        check("rst.done",    64'(bus.o_done),    64'd0);
        check("rst.errcode", 64'(bus.o_errcode), 64'd0);
        check("rst.addr",    64'(bus.o_addr),    64'd0);
        check("rst.data",    64'(bus.o_data),    64'd0);
        check("rst.ll_byte", 64'(bus.o_ll_byte), 64'hff);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        prep_xfer(4'd4, 1'b0, 3, 8'hfe, 1'b1, 1'b0);
        check_xfer("seq16");

        stall_en = 1'b1;
        spur_en  = 1'b1;
        prep_xfer(4'd9, 1'b1, 3, 8'hfe, 1'b1, 1'b0);
        check_xfer("seq512");

        prep_xfer(4'd4, 1'b0, 0, 8'h05, 1'b0, 1'b0);
        check_xfer("errtok");

        prep_xfer(4'd4, 1'b0, 12, 8'hff, 1'b0, 1'b0);
        check_xfer("timeout");

        prep_xfer(4'd4, 1'b0, 2, 8'hfe, 1'b1, 1'b1);
        check_xfer("badcrc");

        prep_xfer(4'd2, 1'b1, 1, 8'hfe, 1'b0, 1'b0);
        check_xfer("clip_lo");

        for (int t = 0; t < 4; t++) begin
            prep_xfer(4'($urandom), 1'($urandom), int'($urandom_range(10)), 8'hfe, 1'b0,
                      1'($urandom_range(3) == 0));
            check_xfer($sformatf("rand%0d", t));
        end

        // Reset in the middle of a data phase.
        prep_xfer(4'd9, 1'b1, 2, 8'hfe, 1'b0, 1'b0);
        cyc = 0;
        while (wr_q.size() < 3 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst.reached", 64'(wr_q.size() >= 3), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst.busy",   64'(bus.o_busy),   64'd0);
        check("midrst.write",  64'(bus.o_write),  64'd0);
        check("midrst.ll_stb", 64'(bus.o_ll_stb), 64'd0);
        check("midrst.addr",   64'(bus.o_addr),   64'd0);
        check("midrst.data",   64'(bus.o_data),   64'd0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        resp_q.delete();
        repeat (6) @(negedge clk);
        check("midrst.no_done", 64'(done_cnt), 64'd0);
        check("midrst.idle",    64'(bus.o_busy), 64'd0);

        prep_xfer(4'd4, 1'b0, 1, 8'hfe, 1'b0, 1'b0);
        check_xfer("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
